// File: rtl/rv32i_dmem_if.sv
// ---------------------------------------------------------------------------
// rv32i_dmem_if
//
// Data-memory interface stage that sits behind the RV32I ALU stage. It turns
// the ALU's registered load/store strobes into one Avalon-MM style bus
// transaction at a time, holds the pipeline with `stall` until that
// transaction finishes, and returns the load data. A per-transaction
// watchdog aborts a transaction that the slave never finishes.
//
// Parameters
//   TIMEOUT    cycles a transaction may spend in WR/RD_CMD/RD_WAIT before it is
//              aborted; 0 disables the watchdog
//   ERR_RDATA  load data handed back to the pipeline when a read is aborted
//
// Ports
//   clk, reset_n        clock; synchronous active-low reset
//   load, store         ALU request strobes (held by the ALU while stall=1)
//   addr                word-aligned byte address
//   st_be, wdata        store byte enables and lane-shifted store data
//   stall               combinational pipeline hold
//   ld_data             load data (bus_readdata bypassed in the completion cycle)
//   bus_address, bus_read, bus_write, bus_byteenable, bus_writedata
//                       registered Avalon-MM command outputs
//   bus_waitrequest, bus_readdata, bus_readdatavalid
//                       Avalon-MM slave responses
//   bus_err             registered one-cycle pulse, high in the cycle right
//                       after a timeout abort
// ---------------------------------------------------------------------------
module rv32i_dmem_if #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        store,
    input  logic [31:0] addr,
    input  logic [3:0]  st_be,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic [31:0] bus_address,
    output logic        bus_read,
    output logic        bus_write,
    output logic [3:0]  bus_byteenable,
    output logic [31:0] bus_writedata,
    input  logic        bus_waitrequest,
    input  logic [31:0] bus_readdata,
    input  logic        bus_readdatavalid,
    output logic        bus_err
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_CMD  = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   tcnt;
    logic [CNT_W:0]     tcnt_inc;
    logic               expire;
    logic               cnt_clr;

    logic [31:0]        ld_data_q, ld_data_q_n;
    logic [31:0]        address_n;
    logic               read_n;
    logic               write_n;
    logic [3:0]         be_n;
    logic [31:0]        wdata_n;
    logic               err_n;

    // The watchdog fires in the cycle whose closing edge would bring the
    // counter up to TIMEOUT, so with TIMEOUT=N the Nth busy cycle is the
    // abort cycle. Counting carries from RD_CMD into RD_WAIT, bounding the
    // whole read rather than each phase separately.
    assign tcnt_inc = {1'b0, tcnt} + 1'b1;
    assign expire   = (TIMEOUT != 0) && (tcnt_inc == (CNT_W + 1)'(TIMEOUT));

    always_comb begin
        state_n     = state;
        address_n   = bus_address;
        read_n      = bus_read;
        write_n     = bus_write;
        be_n        = bus_byteenable;
        wdata_n     = bus_writedata;
        ld_data_q_n = ld_data_q;
        ld_data     = ld_data_q;
        err_n       = 1'b0;
        cnt_clr     = 1'b0;
        stall       = 1'b0;

        case (state)
            IDLE: begin
                // Store has priority; a simultaneous load is dropped.
                if (store) begin
                    address_n = addr;
                    be_n      = st_be;
                    wdata_n   = wdata;
                    write_n   = 1'b1;
                    cnt_clr   = 1'b1;
                    stall     = 1'b1;
                    state_n   = WR;
                end else if (load) begin
                    address_n = addr;
                    be_n      = 4'hF;
                    read_n    = 1'b1;
                    cnt_clr   = 1'b1;
                    stall     = 1'b1;
                    state_n   = RD_CMD;
                end
            end

            WR: begin
                stall = 1'b1;
                if (!bus_waitrequest) begin
                    write_n = 1'b0;
                    stall   = 1'b0;
                    state_n = IDLE;
                end else if (expire) begin
                    write_n = 1'b0;
                    err_n   = 1'b1;
                    stall   = 1'b0;
                    state_n = IDLE;
                end
            end

            RD_CMD: begin
                stall = 1'b1;
                if (!bus_waitrequest && bus_readdatavalid) begin
                    // Zero-latency slave: accepted and answered together.
                    read_n      = 1'b0;
                    ld_data     = bus_readdata;
                    ld_data_q_n = bus_readdata;
                    stall       = 1'b0;
                    state_n     = IDLE;
                end else if (expire) begin
                    read_n      = 1'b0;
                    ld_data     = ERR_RDATA;
                    ld_data_q_n = ERR_RDATA;
                    err_n       = 1'b1;
                    stall       = 1'b0;
                    state_n     = IDLE;
                end else if (!bus_waitrequest) begin
                    read_n  = 1'b0;
                    state_n = RD_WAIT;
                end
            end

            RD_WAIT: begin
                stall = 1'b1;
                if (bus_readdatavalid) begin
                    ld_data     = bus_readdata;
                    ld_data_q_n = bus_readdata;
                    stall       = 1'b0;
                    state_n     = IDLE;
                end else if (expire) begin
                    ld_data     = ERR_RDATA;
                    ld_data_q_n = ERR_RDATA;
                    err_n       = 1'b1;
                    stall       = 1'b0;
                    state_n     = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
                read_n  = 1'b0;
                write_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            bus_address    <= 32'd0;
            bus_read       <= 1'b0;
            bus_write      <= 1'b0;
            bus_byteenable <= 4'd0;
            bus_writedata  <= 32'd0;
            ld_data_q      <= 32'd0;
            bus_err        <= 1'b0;
            tcnt           <= '0;
        end else begin
            state          <= state_n;
            bus_address    <= address_n;
            bus_read       <= read_n;
            bus_write      <= write_n;
            bus_byteenable <= be_n;
            bus_writedata  <= wdata_n;
            ld_data_q      <= ld_data_q_n;
            bus_err        <= err_n;
            if (cnt_clr) begin
                tcnt <= '0;
            end else if (state != IDLE && tcnt != CNT_W'(TIMEOUT)) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_dmem_if.sv
// ---------------------------------------------------------------------------
// tb_rv32i_dmem_if
//
// Directed bench for rv32i_dmem_if (TIMEOUT=8, ERR_RDATA=32'hDEADBEEF).
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled 1 unit later. Expected load results are queued when a load is
// issued and popped when the interface reports completion.
// ---------------------------------------------------------------------------
module tb_rv32i_dmem_if;

    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset_n;
    logic        load;
    logic        store;
    logic [31:0] addr;
    logic [3:0]  st_be;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] ld_data;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [3:0]  bus_byteenable;
    logic [31:0] bus_writedata;
    logic        bus_waitrequest;
    logic [31:0] bus_readdata;
    logic        bus_readdatavalid;
    logic        bus_err;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    rv32i_dmem_if #(
        .TIMEOUT   (8),
        .ERR_RDATA (ERR)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .load              (load),
        .store             (store),
        .addr              (addr),
        .st_be             (st_be),
        .wdata             (wdata),
        .stall             (stall),
        .ld_data           (ld_data),
        .bus_address       (bus_address),
        .bus_read          (bus_read),
        .bus_write         (bus_write),
        .bus_byteenable    (bus_byteenable),
        .bus_writedata     (bus_writedata),
        .bus_waitrequest   (bus_waitrequest),
        .bus_readdata      (bus_readdata),
        .bus_readdatavalid (bus_readdatavalid),
        .bus_err           (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, ld_data, e);
        end
    endtask

    initial begin
        reset_n           = 1'b0;
        load              = 1'b0;
        store             = 1'b0;
        addr              = 32'd0;
        st_be             = 4'd0;
        wdata             = 32'd0;
        bus_waitrequest   = 1'b0;
        bus_readdata      = 32'd0;
        bus_readdatavalid = 1'b0;

        // ---------------- reset state
        cyc(); cyc();
        settle();
        chk("rst_read",    {31'd0, bus_read},  32'd0);
        chk("rst_write",   {31'd0, bus_write}, 32'd0);
        chk("rst_addr",    bus_address,        32'd0);
        chk("rst_be",      {28'd0, bus_byteenable}, 32'd0);
        chk("rst_wdata",   bus_writedata,      32'd0);
        chk("rst_ld_data", ld_data,            32'd0);
        chk("rst_err",     {31'd0, bus_err},   32'd0);
        chk("rst_stall",   {31'd0, stall},     32'd0);
        reset_n = 1'b1;
        cyc();

        // ---------------- zero-wait store
        store = 1'b1; addr = 32'h100; st_be = 4'b0011; wdata = 32'h0000_BEEF;
        settle();
        chk("st_accept_stall", {31'd0, stall}, 32'd1);
        chk("st_accept_wr",    {31'd0, bus_write}, 32'd0);
        cyc();
        settle();
        chk("st_wr",       {31'd0, bus_write}, 32'd1);
        chk("st_addr",     bus_address, 32'h100);
        chk("st_be",       {28'd0, bus_byteenable}, 32'h3);
        chk("st_wdata",    bus_writedata, 32'h0000_BEEF);
        chk("st_no_read",  {31'd0, bus_read}, 32'd0);
        chk("st_done_stall", {31'd0, stall}, 32'd0);
        cyc();
        store = 1'b0;
        settle();
        chk("st_wr_drop",  {31'd0, bus_write}, 32'd0);
        chk("st_idle_stall", {31'd0, stall}, 32'd0);

        // ---------------- load, 3 waitrequest cycles, data 2 cycles after accept
        load = 1'b1; addr = 32'h200; bus_waitrequest = 1'b1;
        exp_q.push_back(32'h1234_5678);
        settle();
        chk("ld_accept_stall", {31'd0, stall}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            settle();
            chk("ld_wait_read",  {31'd0, bus_read}, 32'd1);
            chk("ld_wait_stall", {31'd0, stall}, 32'd1);
        end
        cyc();
        bus_waitrequest = 1'b0;
        settle();
        chk("ld_cmd_read",  {31'd0, bus_read}, 32'd1);
        chk("ld_cmd_be",    {28'd0, bus_byteenable}, 32'hF);
        chk("ld_cmd_addr",  bus_address, 32'h200);
        chk("ld_cmd_stall", {31'd0, stall}, 32'd1);
        cyc();
        settle();
        chk("ld_rw_read",  {31'd0, bus_read}, 32'd0);
        chk("ld_rw_stall", {31'd0, stall}, 32'd1);
        cyc();
        bus_readdatavalid = 1'b1; bus_readdata = 32'h1234_5678;
        settle();
        chk("ld_done_stall", {31'd0, stall}, 32'd0);
        chk_pop("ld_done_data");
        cyc();
        load = 1'b0; bus_readdatavalid = 1'b0; bus_readdata = 32'hFFFF_0000;
        settle();
        chk("ld_hold_data",  ld_data, 32'h1234_5678);
        chk("ld_hold_stall", {31'd0, stall}, 32'd0);

        // ---------------- zero-latency read
        cyc();
        load = 1'b1; addr = 32'h300;
        exp_q.push_back(32'hA5A5_A5A5);
        settle();
        chk("zl_accept_stall", {31'd0, stall}, 32'd1);
        cyc();
        bus_readdatavalid = 1'b1; bus_readdata = 32'hA5A5_A5A5;
        settle();
        chk("zl_read",  {31'd0, bus_read}, 32'd1);
        chk("zl_stall", {31'd0, stall}, 32'd0);
        chk_pop("zl_data");
        cyc();
        load = 1'b0; bus_readdatavalid = 1'b0; bus_readdata = 32'd0;
        settle();
        chk("zl_hold_data", ld_data, 32'hA5A5_A5A5);
        chk("zl_read_drop", {31'd0, bus_read}, 32'd0);

        // ---------------- timeout on a stuck read
        load = 1'b1; addr = 32'h400; bus_waitrequest = 1'b1;
        exp_q.push_back(ERR);
        settle();
        chk("to_accept_stall", {31'd0, stall}, 32'd1);
        for (int i = 1; i < 8; i++) begin
            cyc();
            settle();
            chk("to_wait_stall", {31'd0, stall}, 32'd1);
            chk("to_wait_read",  {31'd0, bus_read}, 32'd1);
            chk("to_wait_err",   {31'd0, bus_err}, 32'd0);
        end
        cyc();
        settle();
        chk("to_abort_stall", {31'd0, stall}, 32'd0);
        chk("to_abort_err",   {31'd0, bus_err}, 32'd0);
        chk_pop("to_abort_data");
        cyc();
        load = 1'b0;
        settle();
        chk("to_err_pulse", {31'd0, bus_err}, 32'd1);
        chk("to_read_drop", {31'd0, bus_read}, 32'd0);
        chk("to_err_data",  ld_data, ERR);
        cyc();
        bus_waitrequest = 1'b0; bus_readdatavalid = 1'b1; bus_readdata = 32'h1111_1111;
        settle();
        chk("to_err_end",   {31'd0, bus_err}, 32'd0);
        chk("to_late_data", ld_data, ERR);
        chk("to_late_stall", {31'd0, stall}, 32'd0);
        cyc();
        bus_readdatavalid = 1'b0;
        settle();
        chk("to_late_hold", ld_data, ERR);

        // ---------------- simultaneous load and store: store wins
        load = 1'b1; store = 1'b1; addr = 32'h40; st_be = 4'hF; wdata = 32'hCAFE_F00D;
        settle();
        chk("ls_accept_stall", {31'd0, stall}, 32'd1);
        cyc();
        settle();
        chk("ls_write",  {31'd0, bus_write}, 32'd1);
        chk("ls_noread", {31'd0, bus_read}, 32'd0);
        chk("ls_addr",   bus_address, 32'h40);
        chk("ls_wdata",  bus_writedata, 32'hCAFE_F00D);
        cyc();
        load = 1'b0; store = 1'b0;
        settle();
        chk("ls_idle_write", {31'd0, bus_write}, 32'd0);
        chk("ls_idle_read",  {31'd0, bus_read}, 32'd0);

        // ---------------- back-to-back store then load
        store = 1'b1; addr = 32'h80; st_be = 4'b0001; wdata = 32'h0000_00AA;
        settle();
        chk("bb_st_stall", {31'd0, stall}, 32'd1);
        cyc();
        settle();
        chk("bb_st_write", {31'd0, bus_write}, 32'd1);
        chk("bb_st_done",  {31'd0, stall}, 32'd0);
        cyc();
        store = 1'b0; load = 1'b1; addr = 32'h84;
        exp_q.push_back(32'h5566_7788);
        settle();
        chk("bb_ld_accept", {31'd0, stall}, 32'd1);
        chk("bb_ld_wdrop",  {31'd0, bus_write}, 32'd0);
        cyc();
        settle();
        chk("bb_ld_read", {31'd0, bus_read}, 32'd1);
        chk("bb_ld_addr", bus_address, 32'h84);
        chk("bb_ld_be",   {28'd0, bus_byteenable}, 32'hF);
        cyc();
        bus_readdatavalid = 1'b1; bus_readdata = 32'h5566_7788;
        settle();
        chk("bb_ld_stall", {31'd0, stall}, 32'd0);
        chk_pop("bb_ld_data");
        cyc();
        load = 1'b0; bus_readdatavalid = 1'b0;
        settle();
        chk("bb_ld_hold", ld_data, 32'h5566_7788);

        // ---------------- reset during RD_WAIT
        load = 1'b1; addr = 32'h500;
        settle();
        cyc();
        settle();
        chk("rr_cmd_read", {31'd0, bus_read}, 32'd1);
        cyc();
        reset_n = 1'b0;
        settle();
        chk("rr_wait_stall", {31'd0, stall}, 32'd1);
        cyc();
        reset_n = 1'b1; load = 1'b0;
        bus_readdatavalid = 1'b1; bus_readdata = 32'h9999_9999;
        settle();
        chk("rr_read",    {31'd0, bus_read}, 32'd0);
        chk("rr_stall",   {31'd0, stall}, 32'd0);
        chk("rr_ld_data", ld_data, 32'd0);
        chk("rr_addr",    bus_address, 32'd0);
        cyc();
        bus_readdatavalid = 1'b0;
        settle();
        chk("rr_late_data", ld_data, 32'd0);
        chk("rr_late_read", {31'd0, bus_read}, 32'd0);

        chk("sb_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
